// File: rtl/voice_scheduler_pkg.sv
// Shared widths, state encoding and load-bus payload for the voice scheduler.
package voice_scheduler_pkg;

    localparam int unsigned NOTE_W = 6;
    localparam int unsigned DUR_W  = 6;
    localparam int unsigned META_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REST = 1'b1
    } state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
        logic [META_W-1:0] meta;
    } voice_bus_t;

endpackage

// File: rtl/free_voice_picker.sv
// Lowest-index priority encoder: one-hot grant of the first free voice.
module free_voice_picker #(
    parameter int unsigned NUM_VOICES = 3
) (
    input  logic [NUM_VOICES-1:0] i_free,
    output logic [NUM_VOICES-1:0] o_grant,
    output logic                  o_any_free
);

    // Two's-complement trick isolates the lowest set bit.
    assign o_grant    = i_free & (~i_free + NUM_VOICES'(1));
    assign o_any_free = |i_free;

endmodule

// File: rtl/voice_scheduler.sv
// Polyphony controller: dispatches notes to the lowest idle voice and
// stalls dispatch for counted rests.
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  beat,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_rest,
    input  logic [NOTE_W-1:0]     req_note,
    input  logic [DUR_W-1:0]      req_duration,
    input  logic [META_W-1:0]     req_meta,
    input  logic [NUM_VOICES-1:0] voice_in_use,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_W-1:0]     voice_note,
    output logic [DUR_W-1:0]      voice_duration,
    output logic [META_W-1:0]     voice_meta,
    output logic                  all_idle
);

    state_e                r_state;
    state_e                w_state_next;
    logic [DUR_W-1:0]      r_rest_cnt;
    voice_bus_t            r_bus;
    logic [NUM_VOICES-1:0] r_load;
    logic [NUM_VOICES-1:0] r_pend_d1;
    logic [NUM_VOICES-1:0] w_pending;
    logic [NUM_VOICES-1:0] w_free;
    logic [NUM_VOICES-1:0] w_grant;
    logic                  w_any_free;
    logic                  w_dur_zero;
    logic                  w_accept;
    logic                  w_accept_note;
    logic                  w_accept_rest;
    logic                  w_rest_beat;

    // A voice stays reserved while its strobe is out and one cycle after,
    // until the player's in_use has had time to rise.
    assign w_pending = r_load | r_pend_d1;
    assign w_free    = ~voice_in_use & ~w_pending;

    free_voice_picker #(
        .NUM_VOICES (NUM_VOICES)
    ) u_picker (
        .i_free     (w_free),
        .o_grant    (w_grant),
        .o_any_free (w_any_free)
    );

    assign w_dur_zero    = (req_duration == '0);
    assign req_ready     = play_enable & (r_state == ST_IDLE)
                         & (w_any_free | req_is_rest | w_dur_zero);
    assign w_accept      = req_valid & req_ready;
    assign w_accept_note = w_accept & ~req_is_rest & ~w_dur_zero;
    assign w_accept_rest = w_accept &  req_is_rest & ~w_dur_zero;
    assign w_rest_beat   = (r_state == ST_REST) & beat & play_enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept_rest) w_state_next = ST_REST;
            ST_REST: if (w_rest_beat && (r_rest_cnt == DUR_W'(1))) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Rest beat counter; frozen while paused.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rest_cnt <= '0;
        end else if (w_accept_rest) begin
            r_rest_cnt <= req_duration;
        end else if (w_rest_beat) begin
            r_rest_cnt <= r_rest_cnt - DUR_W'(1);
        end
    end

    // Load strobe, pending shift and shared bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load    <= '0;
            r_pend_d1 <= '0;
            r_bus     <= '0;
        end else begin
            r_load    <= w_accept_note ? w_grant : '0;
            r_pend_d1 <= r_load;
            if (w_accept_note) begin
                r_bus <= '{note: req_note, dur: req_duration, meta: req_meta};
            end
        end
    end

    assign voice_load     = r_load;
    assign voice_note     = r_bus.note;
    assign voice_duration = r_bus.dur;
    assign voice_meta     = r_bus.meta;
    assign all_idle       = (r_state == ST_IDLE) & ~(|voice_in_use)
                          & ~(|w_pending) & ~(|r_load);

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed scenarios plus a randomized run
// against a cycle-indexed behavioural model with simple voice players.
module tb_voice_scheduler;

    localparam int unsigned NV = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          play_enable;
    logic          beat;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_rest;
    logic [5:0]    req_note;
    logic [5:0]    req_duration;
    logic [2:0]    req_meta;
    logic [NV-1:0] voice_in_use;
    logic [NV-1:0] voice_load;
    logic [5:0]    voice_note;
    logic [5:0]    voice_duration;
    logic [2:0]    voice_meta;
    logic          all_idle;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    voice_scheduler #(
        .NUM_VOICES (NV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .play_enable    (play_enable),
        .beat           (beat),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_rest    (req_is_rest),
        .req_note       (req_note),
        .req_duration   (req_duration),
        .req_meta       (req_meta),
        .voice_in_use   (voice_in_use),
        .voice_load     (voice_load),
        .voice_note     (voice_note),
        .voice_duration (voice_duration),
        .voice_meta     (voice_meta),
        .all_idle       (all_idle)
    );

    task automatic set_req(input logic v, input logic rest, input logic [5:0] n,
                           input logic [5:0] d, input logic [2:0] m);
        req_valid    = v;
        req_is_rest  = rest;
        req_note     = n;
        req_duration = d;
        req_meta     = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        play_enable  = 1'b0;
        beat         = 1'b0;
        voice_in_use = '0;
        set_req(1'b0, 1'b0, 6'd0, 6'd0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (voice_load !== 3'b000) begin failures++; $display("FAIL reset_load got=%b exp=000", voice_load); end
        checks++; if ({voice_note, voice_duration, voice_meta} !== 15'd0) begin failures++; $display("FAIL reset_bus got=%0d/%0d/%0d exp=0/0/0", voice_note, voice_duration, voice_meta); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_paused got=%b exp=0", req_ready); end
        checks++; if (all_idle !== 1'b1) begin failures++; $display("FAIL reset_all_idle got=%b exp=1", all_idle); end
        play_enable = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_run got=%b exp=1", req_ready); end
    endtask

    task automatic test_single_note();
        @(negedge clk);
        play_enable = 1'b1; voice_in_use = '0;
        set_req(1'b1, 1'b0, 6'd12, 6'd10, 3'd3);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (voice_load !== 3'b001) begin failures++; $display("FAIL single_load got=%b exp=001", voice_load); end
        checks++; if ({voice_note, voice_duration, voice_meta} !== {6'd12, 6'd10, 3'd3}) begin failures++; $display("FAIL single_bus got=%0d/%0d/%0d exp=12/10/3", voice_note, voice_duration, voice_meta); end
        checks++; if (all_idle !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", all_idle); end
        @(negedge clk);
        voice_in_use = 3'b001;
        #1;
        checks++; if (voice_load !== 3'b000) begin failures++; $display("FAIL single_pulse got=%b exp=000", voice_load); end
        checks++; if (voice_note !== 6'd12) begin failures++; $display("FAIL single_bus_hold got=%0d exp=12", voice_note); end
        @(negedge clk);
        voice_in_use = 3'b000;
        @(negedge clk);
        #1;
        checks++; if (all_idle !== 1'b1) begin failures++; $display("FAIL single_drain got=%b exp=1", all_idle); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        voice_in_use = '0;
        set_req(1'b1, 1'b0, 6'd20, 6'd5, 3'd1);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", req_ready); end
        @(negedge clk);
        req_note = 6'd21;
        #1;
        checks++; if (voice_load !== 3'b001) begin failures++; $display("FAIL b2b_load0 got=%b exp=001", voice_load); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", req_ready); end
        @(negedge clk);
        voice_in_use = 3'b001; req_note = 6'd22;
        #1;
        checks++; if (voice_load !== 3'b010) begin failures++; $display("FAIL b2b_load1 got=%b exp=010", voice_load); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%b exp=1", req_ready); end
        @(negedge clk);
        voice_in_use = 3'b011; req_note = 6'd23;
        #1;
        checks++; if (voice_load !== 3'b100) begin failures++; $display("FAIL b2b_load2 got=%b exp=100", voice_load); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_pending got=%b exp=0", req_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            voice_in_use = 3'b111;
            #1;
            checks++; if (req_ready !== 1'b0 || voice_load !== 3'b000) begin failures++; $display("FAIL b2b_backpressure k=%0d ready=%b load=%b exp 0/000", k, req_ready, voice_load); end
        end
        @(negedge clk);
        voice_in_use = 3'b101;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_release got=%b exp=1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (voice_load !== 3'b010 || voice_note !== 6'd23) begin failures++; $display("FAIL b2b_refill load=%b note=%0d exp 010/23", voice_load, voice_note); end
        @(negedge clk);
        voice_in_use = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rest(input bit pause);
        int beats;
        bit done;
        @(negedge clk);
        voice_in_use = '0; play_enable = 1'b1; beat = 1'b0;
        set_req(1'b1, 1'b1, 6'd0, 6'd3, 3'd0);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rest_accept pause=%0d got=%b exp=1", pause, req_ready); end
        @(negedge clk);
        set_req(1'b1, 1'b0, 6'd30, 6'd7, 3'd2);
        beats = 0;
        done  = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            if (k > 0) @(negedge clk);
            beat        = (k % 5 == 4);
            play_enable = !(pause && k == 9);
            #1;
            checks++; if (req_ready !== (play_enable && beats >= 3)) begin failures++; $display("FAIL rest_ready pause=%0d k=%0d got=%b exp=%b", pause, k, req_ready, (play_enable && beats >= 3)); end
            if (k == 0) begin
                checks++; if (all_idle !== 1'b0) begin failures++; $display("FAIL rest_busy got=%b exp=0", all_idle); end
            end
            if (req_ready === 1'b1) done = 1'b1;
            if (beat && play_enable) beats++;
        end
        @(negedge clk);
        req_valid = 1'b0; beat = 1'b0; play_enable = 1'b1;
        #1;
        checks++; if (!done || voice_load !== 3'b001 || voice_note !== 6'd30) begin failures++; $display("FAIL rest_next_note pause=%0d accepted=%0d load=%b note=%0d exp 1/001/30", pause, done, voice_load, voice_note); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_zero_dur();
        do_reset();
        play_enable = 1'b1; voice_in_use = 3'b111;
        set_req(1'b1, 1'b0, 6'd40, 6'd0, 3'd5);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL zero_note_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        set_req(1'b1, 1'b1, 6'd0, 6'd0, 3'd0);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL zero_rest_ready got=%b exp=1", req_ready); end
        checks++; if (voice_load !== 3'b000) begin failures++; $display("FAIL zero_note_noload got=%b exp=000", voice_load); end
        @(negedge clk);
        set_req(1'b0, 1'b1, 6'd0, 6'd1, 3'd0);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL zero_stays_idle got=%b exp=1", req_ready); end
        checks++; if (voice_load !== 3'b000 || voice_note !== 6'd0) begin failures++; $display("FAIL zero_rest_noload load=%b note=%0d exp 000/0", voice_load, voice_note); end
        @(negedge clk);
        voice_in_use = '0;
        set_req(1'b0, 1'b0, 6'd0, 6'd0, 3'd0);
        #1;
        checks++; if (all_idle !== 1'b1) begin failures++; $display("FAIL zero_all_idle got=%b exp=1", all_idle); end
    endtask

    task automatic test_pending();
        @(negedge clk);
        voice_in_use = '0; play_enable = 1'b1;
        set_req(1'b0, 1'b0, 6'd0, 6'd0, 3'd0);
        repeat (3) @(negedge clk);
        set_req(1'b1, 1'b0, 6'd1, 6'd9, 3'd0);
        @(negedge clk);
        req_note = 6'd2;
        #1;
        checks++; if (voice_load !== 3'b001) begin failures++; $display("FAIL pend_load0 got=%b exp=001", voice_load); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (voice_load !== 3'b010) begin failures++; $display("FAIL pend_not_v0 got=%b exp=010", voice_load); end
        @(negedge clk);
        set_req(1'b1, 1'b0, 6'd3, 6'd9, 3'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (voice_load !== 3'b001) begin failures++; $display("FAIL pend_window_end got=%b exp=001", voice_load); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_rest();
        @(negedge clk);
        voice_in_use = '0; play_enable = 1'b1; beat = 1'b0;
        set_req(1'b1, 1'b1, 6'd0, 6'd20, 3'd0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 6'd0, 6'd0, 3'd0);
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b0 || all_idle !== 1'b0) begin failures++; $display("FAIL rstrest_in_rest ready=%b idle=%b exp 0/0", req_ready, all_idle); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || all_idle !== 1'b1) begin failures++; $display("FAIL rstrest_cleared ready=%b idle=%b exp 1/1", req_ready, all_idle); end
        set_req(1'b1, 1'b0, 6'd50, 6'd9, 3'd4);
        @(negedge clk);
        set_req(1'b0, 1'b0, 6'd0, 6'd0, 3'd0);
        #1;
        checks++; if (voice_load !== 3'b001) begin failures++; $display("FAIL rstload_inflight got=%b exp=001", voice_load); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (voice_load !== 3'b000 || voice_note !== 6'd0) begin failures++; $display("FAIL rstload_cleared k=%0d load=%b note=%0d exp 000/0", k, voice_load, voice_note); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int            last_acc[NV];
        int            play_cnt[NV];
        int            rest_rem;
        int            cyc;
        logic [5:0]    e_note, e_dur;
        logic [2:0]    e_meta;
        logic [NV-1:0] e_pend, e_free, e_load;
        logic          e_ready, e_idle;
        bit            picked;
        do_reset();
        cyc = 0; rest_rem = 0; e_note = '0; e_dur = '0; e_meta = '0;
        for (int i = 0; i < NV; i++) begin
            last_acc[i] = -10;
            play_cnt[i] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            req_valid   = ($urandom_range(0, 9) < 7);
            req_is_rest = ($urandom_range(0, 9) == 0);
            req_note    = 6'($urandom);
            req_meta    = 3'($urandom);
            if ($urandom_range(0, 9) == 0) req_duration = 6'd0;
            else if (req_is_rest)          req_duration = 6'($urandom_range(1, 4));
            else                           req_duration = 6'($urandom_range(1, 63));
            beat        = ($urandom_range(0, 4) == 0);
            play_enable = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NV; i++) voice_in_use[i] = (play_cnt[i] > 0);
            #1;
            // A voice loaded at edge a shows its strobe in cycle a and stays reserved through a+1.
            for (int i = 0; i < NV; i++) begin
                e_pend[i] = (last_acc[i] == cyc) || (last_acc[i] == cyc - 1);
                e_load[i] = (last_acc[i] == cyc);
            end
            e_free  = ~voice_in_use & ~e_pend;
            e_ready = play_enable && (rest_rem == 0) && ((e_free != '0) || req_is_rest || (req_duration == 6'd0));
            e_idle  = (rest_rem == 0) && (voice_in_use == '0) && (e_pend == '0);
            checks++; if (req_ready !== e_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
            checks++; if (voice_load !== e_load) begin failures++; $display("FAIL rnd_load cyc=%0d got=%b exp=%b", cyc, voice_load, e_load); end
            checks++; if ({voice_note, voice_duration, voice_meta} !== {e_note, e_dur, e_meta}) begin failures++; $display("FAIL rnd_bus cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc, voice_note, voice_duration, voice_meta, e_note, e_dur, e_meta); end
            checks++; if (all_idle !== e_idle) begin failures++; $display("FAIL rnd_all_idle cyc=%0d got=%b exp=%b", cyc, all_idle, e_idle); end
            @(posedge clk);
            cyc++;
            if (req_valid && e_ready) begin
                if (!req_is_rest && req_duration != 6'd0) begin
                    picked = 1'b0;
                    for (int i = 0; i < NV; i++) begin
                        if (!picked && e_free[i]) begin
                            last_acc[i] = cyc;
                            picked      = 1'b1;
                        end
                    end
                    e_note = req_note; e_dur = req_duration; e_meta = req_meta;
                end else if (req_is_rest && req_duration != 6'd0) begin
                    rest_rem = int'(req_duration);
                end
            end else if (rest_rem > 0 && beat && play_enable) begin
                rest_rem--;
            end
            for (int i = 0; i < NV; i++) begin
                if (e_load[i])          play_cnt[i] = int'($urandom_range(1, 6));
                else if (play_cnt[i] > 0) play_cnt[i]--;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_note();
        test_back_to_back();
        test_rest(1'b0);
        test_rest(1'b1);
        test_zero_dur();
        test_pending();
        test_reset_rest();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
